snake_move_ctrl: RTL and testbench

//  Sequences the snake head square drawn by the pixel colouriser: latches direction keys, paces moves off the
//  VGA frame rate, and steps box_x/box_y one BLOCK_W cell per move. Sits between the key debouncers, the VGA

---
 rtl/snake_move_ctrl_pkg.sv | 26 ++
 rtl/snake_move_ctrl_if.sv | 27 ++
 rtl/snake_move_ctrl_step_timer.sv | 35 +++
 rtl/snake_move_ctrl.sv | 167 ++++++++++++++++
 tb/tb_snake_move_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_move_ctrl_pkg.sv
// Shared encodings for the snake game blocks: direction codes, game-run states
// and the default cell size reused by the display and future body/food logic.
package snake_move_ctrl_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int BLOCK_W_DEF = 10;

    // Up/down and left/right differ only in bit 0, so the reverse is a single flip.
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_move_ctrl_if.sv
// Groups the frame/key inputs and the head position outputs of snake_move_ctrl.
// master drives frame_start and the keys; slave is the movement controller.
interface snake_move_ctrl_if;

    logic       frame_start;
    logic       key_up;
    logic       key_down;
    logic       key_left;
    logic       key_right;
    logic       key_pause;
    logic [9:0] box_x;
    logic [9:0] box_y;
    logic [1:0] dir;
    logic       move_pulse;
    logic       game_over;

    modport master (
        output frame_start, key_up, key_down, key_left, key_right, key_pause,
        input  box_x, box_y, dir, move_pulse, game_over
    );

    modport slave (
        input  frame_start, key_up, key_down, key_left, key_right, key_pause,
        output box_x, box_y, dir, move_pulse, game_over
    );

endinterface

// File: rtl/snake_move_ctrl_step_timer.sv
// Counts frame_start pulses while enabled and flags the frame that completes a
// step; the count is frozen when disabled and forced to zero by clear.
module snake_move_ctrl_step_timer #(
    parameter int FRAMES_PER_STEP = 15
) (
    input  logic vga_clk,
    input  logic sys_rst_n,
    input  logic frame_start,
    input  logic enable,
    input  logic clear,
    output logic step_fire
);

    localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_STEP - 1);

    logic [CW-1:0] step_cnt;

    assign step_fire = enable && frame_start && (step_cnt == LAST);

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            step_cnt <= '0;
        end else if (clear) begin
            step_cnt <= '0;
        end else if (enable && frame_start) begin
            if (step_fire) begin
                step_cnt <= '0;
            end else begin
                step_cnt <= step_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake head movement controller: latches direction keys, paces moves off the
// frame rate and steps the head one cell per move. Define SNAKE_WRAP_EN to wrap at edges.
module snake_move_ctrl
    import snake_move_ctrl_pkg::*;
#(
    parameter int H_DISP          = 800,
    parameter int V_DISP          = 600,
    parameter int BLOCK_W         = BLOCK_W_DEF,
    parameter int FRAMES_PER_STEP = 15,
    parameter int START_X         = 400,
    parameter int START_Y         = 300
) (
    input  logic              vga_clk,
    input  logic              sys_rst_n,
    snake_move_ctrl_if.slave  bus
);

    localparam logic [10:0] STEP  = 11'(BLOCK_W);
    localparam logic [10:0] X_MAX = 11'(H_DISP - BLOCK_W);
    localparam logic [10:0] Y_MAX = 11'(V_DISP - BLOCK_W);
    localparam logic [9:0]  X_RST = 10'(START_X);
    localparam logic [9:0]  Y_RST = 10'(START_Y);

    state_t     state;
    dir_t       dir_q;
    dir_t       pend_dir;
    logic [9:0] box_x;
    logic [9:0] box_y;
    logic       move_pulse;

    logic       key_hit;
    dir_t       key_dir;
    logic       key_ok;
    logic       step_fire;
    logic       timer_en;
    logic       timer_clr;

    logic [10:0] x_ext, y_ext, x_inc, x_dec, y_inc, y_dec;
    logic [9:0]  next_x, next_y;

    // Fixed key priority up > down > left > right; a reversing winner discards the cycle.
    always_comb begin
        key_hit = 1'b1;
        key_dir = DIR_RIGHT;
        if (bus.key_up) begin
            key_dir = DIR_UP;
        end else if (bus.key_down) begin
            key_dir = DIR_DOWN;
        end else if (bus.key_left) begin
            key_dir = DIR_LEFT;
        end else if (bus.key_right) begin
            key_dir = DIR_RIGHT;
        end else begin
            key_hit = 1'b0;
        end
    end

    assign key_ok    = key_hit && (key_dir != reverse_dir(dir_q));
    assign timer_en  = (state == ST_RUN) && !bus.key_pause;
    assign timer_clr = (state == ST_IDLE);

    snake_move_ctrl_step_timer #(
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_step_timer (
        .vga_clk     (vga_clk),
        .sys_rst_n   (sys_rst_n),
        .frame_start (bus.frame_start),
        .enable      (timer_en),
        .clear       (timer_clr),
        .step_fire   (step_fire)
    );

    assign x_ext = {1'b0, box_x};
    assign y_ext = {1'b0, box_y};
    assign x_inc = x_ext + STEP;
    assign x_dec = x_ext - STEP;
    assign y_inc = y_ext + STEP;
    assign y_dec = y_ext - STEP;

    // Candidate position one cell along pend_dir; out-of-range candidates become the opposite edge.
    always_comb begin
        next_x = box_x;
        next_y = box_y;
        case (pend_dir)
            DIR_UP:    next_y = y_dec[10]     ? Y_MAX[9:0] : y_dec[9:0];
            DIR_DOWN:  next_y = (y_inc > Y_MAX) ? 10'd0    : y_inc[9:0];
            DIR_LEFT:  next_x = x_dec[10]     ? X_MAX[9:0] : x_dec[9:0];
            DIR_RIGHT: next_x = (x_inc > X_MAX) ? 10'd0    : x_inc[9:0];
            default: ;
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign bus.game_over = 1'b0;
`else
    logic edge_hit;
    logic game_over;

    assign edge_hit = ((pend_dir == DIR_UP)    && y_dec[10])       ||
                      ((pend_dir == DIR_DOWN)  && (y_inc > Y_MAX)) ||
                      ((pend_dir == DIR_LEFT)  && x_dec[10])       ||
                      ((pend_dir == DIR_RIGHT) && (x_inc > X_MAX));
    assign bus.game_over = game_over;
`endif

    // Game-run FSM with direction latch and position update; all outputs registered.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_IDLE;
            dir_q      <= DIR_RIGHT;
            pend_dir   <= DIR_RIGHT;
            box_x      <= X_RST;
            box_y      <= Y_RST;
            move_pulse <= 1'b0;
`ifndef SNAKE_WRAP_EN
            game_over  <= 1'b0;
`endif
        end else begin
            move_pulse <= 1'b0;
            if ((state != ST_OVER) && key_ok) begin
                pend_dir <= key_dir;
            end
            case (state)
                ST_IDLE: begin
                    if (key_hit) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.key_pause) begin
                        state <= ST_PAUSE;
                    end
                    if (step_fire) begin
                        dir_q <= pend_dir;
`ifdef SNAKE_WRAP_EN
                        box_x      <= next_x;
                        box_y      <= next_y;
                        move_pulse <= 1'b1;
`else
                        if (edge_hit) begin
                            state     <= ST_OVER;
                            game_over <= 1'b1;
                        end else begin
                            box_x      <= next_x;
                            box_y      <= next_y;
                            move_pulse <= 1'b1;
                        end
`endif
                    end
                end
                ST_PAUSE: begin
                    if (bus.key_pause) begin
                        state <= ST_RUN;
                    end
                end
                ST_OVER: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.box_x      = box_x;
    assign bus.box_y      = box_y;
    assign bus.dir        = dir_q;
    assign bus.move_pulse = move_pulse;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed self-checking bench for snake_move_ctrl; edge expectations follow SNAKE_WRAP_EN.
module tb_snake_move_ctrl;

    logic vga_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    snake_move_ctrl_if bus ();

    snake_move_ctrl dut (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic idle_inputs();
        bus.frame_start = 1'b0;
        bus.key_up      = 1'b0;
        bus.key_down    = 1'b0;
        bus.key_left    = 1'b0;
        bus.key_right   = 1'b0;
        bus.key_pause   = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        repeat (2) @(negedge vga_clk);
        sys_rst_n = 1'b1;
        @(negedge vga_clk);
    endtask

    task automatic press(input logic u, input logic d, input logic l, input logic r, input logic p);
        @(negedge vga_clk);
        bus.key_up    = u;
        bus.key_down  = d;
        bus.key_left  = l;
        bus.key_right = r;
        bus.key_pause = p;
        @(negedge vga_clk);
        idle_inputs();
    endtask

    // mp_seen is sampled one clock after frame_start, mp_after one clock later still.
    task automatic frame(output logic mp_seen, output logic mp_after);
        @(negedge vga_clk);
        bus.frame_start = 1'b1;
        @(negedge vga_clk);
        bus.frame_start = 1'b0;
        mp_seen = bus.move_pulse;
        @(negedge vga_clk);
        mp_after = bus.move_pulse;
    endtask

    task automatic run_frames(input int n, output int pulses, output int last_idx);
        logic a, b;
        pulses   = 0;
        last_idx = 0;
        for (int i = 1; i <= n; i++) begin
            frame(a, b);
            if (a === 1'b1) begin
                pulses++;
                last_idx = i;
            end
        end
    endtask

    task automatic test_reset();
        int p, l;
        do_reset();
        tests_run++;
        if (bus.box_x !== 10'd400) begin
            tests_failed++; $display("[TB] FAIL reset_x: got %0d expected 400", bus.box_x);
        end
        tests_run++;
        if (bus.box_y !== 10'd300) begin
            tests_failed++; $display("[TB] FAIL reset_y: got %0d expected 300", bus.box_y);
        end
        tests_run++;
        if (bus.dir !== 2'd3) begin
            tests_failed++; $display("[TB] FAIL reset_dir: got %0d expected 3", bus.dir);
        end
        tests_run++;
        if (bus.move_pulse !== 1'b0 || bus.game_over !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL reset_flags: got mp=%0b go=%0b expected 0 0", bus.move_pulse, bus.game_over);
        end
        run_frames(100, p, l);
        tests_run++;
        if (p !== 0) begin
            tests_failed++; $display("[TB] FAIL idle_no_move: got %0d pulses expected 0", p);
        end
        tests_run++;
        if (bus.box_x !== 10'd400 || bus.box_y !== 10'd300) begin
            tests_failed++; $display("[TB] FAIL idle_pos: got (%0d,%0d) expected (400,300)", bus.box_x, bus.box_y);
        end
    endtask

    task automatic test_run_right();
        logic a, b;
        int stray = 0;
        press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 30; i++) begin
            frame(a, b);
            if (i == 15 || i == 30) begin
                tests_run++;
                if (a !== 1'b1 || bus.box_x !== ((i == 15) ? 10'd410 : 10'd420)) begin
                    tests_failed++;
                    $display("[TB] FAIL run_move_%0d: got mp=%0b x=%0d expected mp=1 x=%0d",
                             i, a, bus.box_x, (i == 15) ? 410 : 420);
                end
                tests_run++;
                if (b !== 1'b0) begin
                    tests_failed++; $display("[TB] FAIL run_pulse_width_%0d: got %0b expected 0", i, b);
                end
            end else if (a === 1'b1) begin
                stray++;
            end
        end
        tests_run++;
        if (stray !== 0 || bus.box_y !== 10'd300) begin
            tests_failed++; $display("[TB] FAIL run_stray: got stray=%0d y=%0d expected 0 300", stray, bus.box_y);
        end
    endtask

    task automatic test_key_priority();
        int p, l;
        press(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_frames(15, p, l);
        tests_run++;
        if (p !== 1 || l !== 15) begin
            tests_failed++; $display("[TB] FAIL prio_timing: got %0d pulses last=%0d expected 1 at 15", p, l);
        end
        tests_run++;
        if (bus.box_x !== 10'd420 || bus.box_y !== 10'd290 || bus.dir !== 2'd0) begin
            tests_failed++; $display("[TB] FAIL prio_up: got (%0d,%0d) dir=%0d expected (420,290) dir=0", bus.box_x, bus.box_y, bus.dir);
        end
        press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_frames(15, p, l);
        tests_run++;
        if (bus.box_y !== 10'd280 || bus.dir !== 2'd0) begin
            tests_failed++; $display("[TB] FAIL reverse_ignored: got y=%0d dir=%0d expected y=280 dir=0", bus.box_y, bus.dir);
        end
    endtask

    task automatic test_pause();
        int p, l;
        logic a;
        do_reset();
        press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frames(7, p, l);
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frames(20, p, l);
        tests_run++;
        if (p !== 0 || bus.box_x !== 10'd400) begin
            tests_failed++; $display("[TB] FAIL pause_frozen: got %0d pulses x=%0d expected 0 400", p, bus.box_x);
        end
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frames(8, p, l);
        tests_run++;
        if (p !== 1 || l !== 8 || bus.box_x !== 10'd410) begin
            tests_failed++; $display("[TB] FAIL pause_resume: got %0d pulses last=%0d x=%0d expected 1 at 8 x=410", p, l, bus.box_x);
        end
        run_frames(14, p, l);
        @(negedge vga_clk);
        bus.frame_start = 1'b1;
        bus.key_pause   = 1'b1;
        @(negedge vga_clk);
        idle_inputs();
        a = bus.move_pulse;
        tests_run++;
        if (a !== 1'b0 || bus.box_x !== 10'd410) begin
            tests_failed++; $display("[TB] FAIL pause_wins: got mp=%0b x=%0d expected mp=0 x=410", a, bus.box_x);
        end
        press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frames(1, p, l);
        tests_run++;
        if (p !== 1 || bus.box_x !== 10'd410 || bus.box_y !== 10'd310 || bus.dir !== 2'd1) begin
            tests_failed++; $display("[TB] FAIL pause_key_latch: got %0d pulses (%0d,%0d) dir=%0d expected 1 (410,310) dir=1",
                                     p, bus.box_x, bus.box_y, bus.dir);
        end
    endtask

    task automatic test_edge();
        int p, l;
        do_reset();
        press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frames(39 * 15, p, l);
        tests_run++;
        if (p !== 39 || bus.box_x !== 10'd790) begin
            tests_failed++; $display("[TB] FAIL edge_reach: got %0d pulses x=%0d expected 39 790", p, bus.box_x);
        end
        run_frames(15, p, l);
`ifdef SNAKE_WRAP_EN
        tests_run++;
        if (p !== 1 || bus.box_x !== 10'd0 || bus.game_over !== 1'b0 || bus.dir !== 2'd3) begin
            tests_failed++; $display("[TB] FAIL edge_wrap: got %0d pulses x=%0d go=%0b dir=%0d expected 1 0 0 3",
                                     p, bus.box_x, bus.game_over, bus.dir);
        end
`else
        tests_run++;
        if (p !== 0 || bus.box_x !== 10'd790 || bus.game_over !== 1'b1 || bus.dir !== 2'd3) begin
            tests_failed++; $display("[TB] FAIL edge_over: got %0d pulses x=%0d go=%0b dir=%0d expected 0 790 1 3",
                                     p, bus.box_x, bus.game_over, bus.dir);
        end
        press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_frames(15, p, l);
        tests_run++;
        if (p !== 0 || bus.box_y !== 10'd300 || bus.dir !== 2'd3 || bus.game_over !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL over_sticky: got %0d pulses y=%0d dir=%0d go=%0b expected 0 300 3 1",
                                     p, bus.box_y, bus.dir, bus.game_over);
        end
`endif
    endtask

    task automatic test_reset_mid_run();
        int p, l;
        do_reset();
        press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frames(25, p, l);
        tests_run++;
        if (bus.box_x !== 10'd410) begin
            tests_failed++; $display("[TB] FAIL pre_reset_x: got %0d expected 410", bus.box_x);
        end
        @(negedge vga_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.box_x !== 10'd400 || bus.box_y !== 10'd300 || bus.dir !== 2'd3 || bus.game_over !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL async_reset: got (%0d,%0d) dir=%0d go=%0b expected (400,300) 3 0",
                                     bus.box_x, bus.box_y, bus.dir, bus.game_over);
        end
        @(negedge vga_clk);
        sys_rst_n = 1'b1;
        press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frames(15, p, l);
        tests_run++;
        if (p !== 1 || l !== 15 || bus.box_x !== 10'd410) begin
            tests_failed++; $display("[TB] FAIL post_reset_count: got %0d pulses last=%0d x=%0d expected 1 at 15 x=410",
                                     p, l, bus.box_x);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_run_right();
        test_key_priority();
        test_pause();
        test_edge();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
